// File: rtl/cache_fill_fsm_param_pkg.sv
// -----------------------------------------------------------------------------
// cache_fill_pkg
// Shared types and width helpers for the parametrised cache fill controller.
//   state_t     : controller state encoding (IDLE / FILL / DRAIN)
//   calc_idx_w  : width of a word index within a block
//   calc_off_w  : width of the byte offset within a block
//   calc_byte_w : width of the byte offset within a word
// -----------------------------------------------------------------------------
package cache_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int calc_idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic int calc_off_w(input int words, input int bytes_per_word);
        return $clog2(words * bytes_per_word);
    endfunction

    function automatic int calc_byte_w(input int bytes_per_word);
        return $clog2(bytes_per_word);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_param_if.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm_param_if
// Memory request / return bus between the fill controller and memory.
//   memory_read       : request valid (controller -> memory)
//   memory_address    : word address of the request (controller -> memory)
//   memory_ready      : memory accepts the request this cycle (memory -> controller)
//   memory_data       : returned word (memory -> controller / data array)
//   memory_data_valid : returned word valid this cycle (memory -> controller)
// Modports: master = fill controller, slave = memory.
// -----------------------------------------------------------------------------
interface cache_fill_fsm_param_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              memory_read;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_ready;
    logic [DATA_W-1:0] memory_data;
    logic              memory_data_valid;

    modport master (
        output memory_read,
        output memory_address,
        input  memory_ready,
        input  memory_data,
        input  memory_data_valid
    );

    modport slave (
        input  memory_read,
        input  memory_address,
        output memory_ready,
        output memory_data,
        output memory_data_valid
    );
endinterface

// File: rtl/cache_fill_fsm_param_counter.sv
// -----------------------------------------------------------------------------
// fill_word_counter
// Counts words of one block fill and produces the (optionally rotated) word
// index. Used once for the request side and once for the return side.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a new fill; loads start_idx and clears the count
//   inc       : one word handled this cycle
//   start_idx : index of the first word of the fill
//   idx       : current word index, start_idx + count modulo block size
//   count     : words handled so far in this fill
//   last      : current word is the final word of the block
// -----------------------------------------------------------------------------
module fill_word_counter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int IDX_W           = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inc,
    input  logic [IDX_W-1:0] start_idx,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W:0]   count,
    output logic             last
);

    logic [IDX_W-1:0] first_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_idx <= '0;
            count     <= '0;
        end else if (start) begin
            first_idx <= start_idx;
            count     <= '0;
        end else if (inc) begin
            count <= count + (IDX_W+1)'(1);
        end
    end

    // Block size is a power of two, so truncating the sum gives the wrap.
    assign idx  = first_idx + count[IDX_W-1:0];
    assign last = (count == (IDX_W+1)'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_fsm_param.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm_param
// Cache-miss fill controller: on a miss, requests every word of the block from
// a pipelined memory, writes each returned word into the data array, and
// writes the tag together with the final word.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   miss_detected     : miss from tag logic (sampled in IDLE only)
//   miss_address      : missing address
//   fsm_busy          : fill in progress (pipeline stall)
//   mem               : memory request/return bus (master side)
//   write_data_array  : data-array write enable (same cycle as returned data)
//   fill_word_index   : word slot being written
//   write_tag_array   : tag-array write pulse, with the final data write
//   crit_word_valid   : first data write of a fill (critical-word-first only)
// Optional feature macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN
//   Defined   : fill starts at the missed word and wraps; adds crit_word_valid.
//   Undefined : fill order is always word 0 upward.
// -----------------------------------------------------------------------------
module cache_fill_fsm_param
    import cache_fill_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int BYTES_PER_WORD  = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     miss_detected,
    input  logic [ADDR_W-1:0]                        miss_address,
    output logic                                     fsm_busy,
    cache_fill_fsm_param_if.master                   mem,
    output logic                                     write_data_array,
    output logic [calc_idx_w(WORDS_PER_BLOCK)-1:0]   fill_word_index,
    output logic                                     write_tag_array
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    ,
    output logic                                     crit_word_valid
`endif
);

    localparam int IDX_W  = calc_idx_w(WORDS_PER_BLOCK);
    localparam int OFF_W  = calc_off_w(WORDS_PER_BLOCK, BYTES_PER_WORD);
    localparam int BYTE_W = calc_byte_w(BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic              start_fill, accept, rx_word, done;
    logic [IDX_W-1:0]  start_idx, issue_idx, recv_idx;
    logic [IDX_W:0]    issue_count, recv_count;
    logic              issue_last, recv_last;
    logic [DATA_W-1:0] unused_fill_data;
    logic              unused_ok;

    assign start_fill = (state == IDLE) && miss_detected;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = IDX_W'(miss_address >> BYTE_W);
`else
    assign start_idx = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            state <= state_nxt;
            if (start_fill) begin
                base <= miss_address & ~OFF_MASK;
            end
        end
    end

    fill_word_counter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK), .IDX_W(IDX_W)) u_issue_cnt (
        .clk       (clk),
        .rst       (rst),
        .start     (start_fill),
        .inc       (accept),
        .start_idx (start_idx),
        .idx       (issue_idx),
        .count     (issue_count),
        .last      (issue_last)
    );

    fill_word_counter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK), .IDX_W(IDX_W)) u_recv_cnt (
        .clk       (clk),
        .rst       (rst),
        .start     (start_fill),
        .inc       (rx_word),
        .start_idx (start_idx),
        .idx       (recv_idx),
        .count     (recv_count),
        .last      (recv_last)
    );

    always_comb begin
        state_nxt          = state;
        fsm_busy           = 1'b0;
        mem.memory_read    = 1'b0;
        mem.memory_address = '0;
        accept             = 1'b0;
        write_data_array   = 1'b0;
        write_tag_array    = 1'b0;
        fill_word_index    = '0;

        case (state)
            IDLE: begin
                if (miss_detected) state_nxt = FILL;
            end
            FILL: begin
                fsm_busy           = 1'b1;
                mem.memory_read    = 1'b1;
                mem.memory_address = base + (ADDR_W'(issue_idx) << BYTE_W);
                accept             = mem.memory_ready;
                if (accept && issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                fsm_busy = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // Returned data is only meaningful during a fill; anything arriving
        // in IDLE (e.g. left over from an aborted fill) is dropped.
        rx_word = mem.memory_data_valid && fsm_busy;
        done    = rx_word && recv_last;
        // A zero-latency memory can finish the block while still in FILL.
        if (done) state_nxt = IDLE;

        write_data_array = rx_word;
        write_tag_array  = done;
        if (fsm_busy) fill_word_index = recv_idx;
    end

    // Data goes straight from the bus into the data array outside this block.
    assign unused_fill_data = mem.memory_data;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign crit_word_valid = rx_word && (recv_count == '0);
    assign unused_ok       = ^{issue_count, unused_fill_data};
`else
    assign unused_ok       = ^{issue_count, recv_count, unused_fill_data};
`endif

endmodule

// File: tb/tb_cache_fill_fsm_param.sv
`timescale 1ns/1ps
module tb_cache_fill_fsm_param;

    localparam int LAT = 4;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // default configuration
    logic        miss_detected, fsm_busy, write_data_array, write_tag_array;
    logic [15:0] miss_address;
    logic [2:0]  fill_word_index;
    cache_fill_fsm_param_if #(.ADDR_W(16), .DATA_W(16)) m ();
    // 4-word / 32-bit configuration
    logic        miss4, busy4, wr4, tag4;
    logic [15:0] maddr4;
    logic [1:0]  idx4;
    cache_fill_fsm_param_if #(.ADDR_W(16), .DATA_W(32)) m4 ();
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic        crit, crit4;
`endif

    cache_fill_fsm_param u_dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .fsm_busy(fsm_busy), .mem(m),
        .write_data_array(write_data_array), .fill_word_index(fill_word_index),
        .write_tag_array(write_tag_array)
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        , .crit_word_valid(crit)
`endif
    );

    cache_fill_fsm_param #(.ADDR_W(16), .DATA_W(32), .WORDS_PER_BLOCK(4), .BYTES_PER_WORD(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .miss_detected(miss4), .miss_address(maddr4),
        .fsm_busy(busy4), .mem(m4),
        .write_data_array(wr4), .fill_word_index(idx4),
        .write_tag_array(tag4)
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        , .crit_word_valid(crit4)
`endif
    );

    typedef struct { int due; logic [15:0] data; } pend_t;
    pend_t       pend[$];
    int          cyc, req_cnt, stall_at, stall_len, stall_done, busy_cnt;
    logic [15:0] addr_log[$], stall_log[$];
    int          widx_log[$], wcyc_log[$], tag_log[$], crit_log[$];
    logic [15:0] exp_addr[8];
    int          exp_idx[8];
    int          n_vec = 0, n_miss = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete(); stall_log.delete(); widx_log.delete();
        wcyc_log.delete(); tag_log.delete(); crit_log.delete();
        cyc = 0; req_cnt = 0; stall_at = -1; stall_len = 0; stall_done = 0; busy_cnt = 0;
    endtask

    // One clock of the default DUT with a pipelined memory model: a request
    // accepted in cycle c returns its data in cycle c+LAT+1.
    task automatic cycle();
        @(posedge clk); #1;
        cyc++;
        miss_detected       = 1'b0;
        m.memory_data_valid = 1'b0;
        m.memory_data       = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m.memory_data_valid = 1'b1;
            m.memory_data       = pend[0].data;
            void'(pend.pop_front());
        end
        m.memory_ready = !(req_cnt == stall_at && stall_done < stall_len);
        if (!m.memory_ready) stall_done++;
        #1;
        if (fsm_busy) busy_cnt++;
        if (m.memory_read && m.memory_ready) begin
            addr_log.push_back(m.memory_address);
            pend.push_back('{cyc + LAT + 1, ~m.memory_address});
            req_cnt++;
        end else if (m.memory_read) begin
            stall_log.push_back(m.memory_address);
        end
        if (write_data_array) begin
            widx_log.push_back(int'(fill_word_index));
            wcyc_log.push_back(cyc);
        end
        if (write_tag_array) tag_log.push_back(cyc);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        if (crit) crit_log.push_back(cyc);
`endif
    endtask

    task automatic run_until_tag(input int budget);
        for (int c = 0; c < budget; c++) begin
            cycle();
            if (tag_log.size() > 0) break;
        end
    endtask

    task automatic set_exp(input logic [15:0] miss);
        int s;
        s = CWF ? int'((miss >> 1) & 16'h7) : 0;
        for (int i = 0; i < 8; i++) begin
            exp_idx[i]  = (s + i) % 8;
            exp_addr[i] = (miss & 16'hFFF0) + 16'(exp_idx[i] * 2);
        end
    endtask

    task automatic check_fill(input string nm);
        chk_val({nm, "_nreq"}, addr_log.size(), 8);
        chk_val({nm, "_nwr"},  widx_log.size(), 8);
        chk_val({nm, "_ntag"}, tag_log.size(), 1);
        for (int i = 0; i < 8; i++) begin
            if (i < addr_log.size()) chk_val($sformatf("%s_addr%0d", nm, i), addr_log[i], exp_addr[i]);
            if (i < widx_log.size()) chk_val($sformatf("%s_idx%0d", nm, i), widx_log[i], exp_idx[i]);
        end
        if (tag_log.size() == 1 && wcyc_log.size() == 8)
            chk_val({nm, "_tagcyc"}, tag_log[0], wcyc_log[7]);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        chk_val({nm, "_ncrit"}, crit_log.size(), 1);
        if (crit_log.size() == 1 && wcyc_log.size() > 0)
            chk_val({nm, "_critcyc"}, crit_log[0], wcyc_log[0]);
`endif
    endtask

    task automatic check_outputs_zero(input string nm);
        chk_val({nm, "_busy"}, fsm_busy, 0);
        chk_val({nm, "_read"}, m.memory_read, 0);
        chk_val({nm, "_addr"}, m.memory_address, 0);
        chk_val({nm, "_wr"},   write_data_array, 0);
        chk_val({nm, "_idx"},  fill_word_index, 0);
        chk_val({nm, "_tag"},  write_tag_array, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a4[$];
        int          i4[$], w4[$], t4[$], c4[$];
        int          b4;
        logic        prev_acc4;
        logic [15:0] prev_addr4;

        miss_detected = 1'b0; miss_address = '0;
        m.memory_ready = 1'b0; m.memory_data = '0; m.memory_data_valid = 1'b1;
        miss4 = 1'b0; maddr4 = '0;
        m4.memory_ready = 1'b0; m4.memory_data = '0; m4.memory_data_valid = 1'b0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        // reset state, with a stray valid present
        check_outputs_zero("rst");
        m.memory_data_valid = 1'b0;
        @(negedge clk) rst = 1'b0;

        // T1: basic fill, ready always high
        clear_logs(); set_exp(16'h1236);
        miss_address = 16'h1236; miss_detected = 1'b1;
        run_until_tag(40);
        check_fill("t1");
        chk_val("t1_first_addr", addr_log.size() > 0 ? addr_log[0] : 16'hxxxx, CWF ? 16'h1236 : 16'h1230);
        chk_val("t1_last_addr",  addr_log.size() > 7 ? addr_log[7] : 16'hxxxx, CWF ? 16'h1234 : 16'h123E);
        chk_val("t1_first_wcyc", wcyc_log.size() > 0 ? wcyc_log[0] : -1, 6);
        cycle();
        chk_val("t1_busy_fall", fsm_busy, 0);
        chk_val("t1_busy_cycles", busy_cnt, 13);

        // T2: ready low for 3 cycles while the 2nd request is presented
        clear_logs(); set_exp(16'h1236);
        stall_at = 1; stall_len = 3;
        miss_address = 16'h1236; miss_detected = 1'b1;
        run_until_tag(60);
        check_fill("t2");
        chk_val("t2_nstall", stall_log.size(), 3);
        for (int i = 0; i < stall_log.size(); i++)
            chk_val($sformatf("t2_stall_addr%0d", i), stall_log[i], CWF ? 16'h1238 : 16'h1232);
        chk_val("t2_busy_cycles", busy_cnt, 16);
        cycle();

        // T3: reset in DRAIN after 5 words
        clear_logs();
        miss_address = 16'h1236; miss_detected = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (wcyc_log.size() == 5) break;
        end
        chk_val("t3_nwr_before", wcyc_log.size(), 5);
        chk_val("t3_drain_read", m.memory_read, 0);
        chk_val("t3_drain_busy", fsm_busy, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("t3_rst");
        widx_log.delete(); wcyc_log.delete(); tag_log.delete(); crit_log.delete(); busy_cnt = 0;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk_val("t3_idle_writes", widx_log.size(), 0);
        chk_val("t3_idle_tags", tag_log.size(), 0);
        chk_val("t3_idle_busy", busy_cnt, 0);
        chk_val("t3_pend_drained", pend.size(), 0);

        clear_logs(); set_exp(16'h2000);
        miss_address = 16'h2000; miss_detected = 1'b1;
        run_until_tag(40);
        check_fill("t3b");

        // T4: back-to-back miss presented in the cycle busy falls
        cycle();
        chk_val("t4_busy_fall", fsm_busy, 0);
        clear_logs(); set_exp(16'h4000);
        miss_address = 16'h4000; miss_detected = 1'b1;
        cycle();
        chk_val("t4_first_read", m.memory_read, 1);
        chk_val("t4_first_addr", m.memory_address, 16'h4000);
        run_until_tag(40);
        check_fill("t4");
        cycle();

        // T5: 4 words x 32 bits, 4-byte stride, one-cycle memory
        b4 = 0; prev_acc4 = 1'b0; prev_addr4 = '0;
        maddr4 = 16'h0018; miss4 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            miss4 = 1'b0;
            m4.memory_ready      = 1'b1;
            m4.memory_data_valid = prev_acc4;
            m4.memory_data       = {16'h0, ~prev_addr4};
            #1;
            if (busy4) b4++;
            prev_acc4  = m4.memory_read && m4.memory_ready;
            prev_addr4 = m4.memory_address;
            if (prev_acc4) a4.push_back(m4.memory_address);
            if (wr4) begin i4.push_back(int'(idx4)); w4.push_back(c); end
            if (tag4) t4.push_back(c);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            if (crit4) c4.push_back(c);
`endif
            if (!busy4) break;
        end
        chk_val("t5_nreq", a4.size(), 4);
        chk_val("t5_nwr",  i4.size(), 4);
        chk_val("t5_ntag", t4.size(), 1);
        for (int i = 0; i < 4; i++) begin
            if (i < a4.size()) chk_val($sformatf("t5_addr%0d", i), a4[i],
                CWF ? 16'h0010 + 16'(((i + 2) % 4) * 4) : 16'h0010 + 16'(i * 4));
            if (i < i4.size()) chk_val($sformatf("t5_idx%0d", i), i4[i], CWF ? (i + 2) % 4 : i);
        end
        if (t4.size() == 1 && w4.size() == 4) chk_val("t5_tagcyc", t4[0], w4[3]);
        chk_val("t5_busy_cycles", b4, 5);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        chk_val("t5_ncrit", c4.size(), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm_param.md
Name: cache_fill_fsm_param

Overview:
- Parametrised cache-miss fill controller for the cache hierarchy.
- On a miss, it fetches a whole block from the multi-cycle, pipelined memory, one word per accepted request.
- It writes each returned word into the data array, then writes the tag once the block is complete.
- Generalises the fixed 8-word / 16-bit fill engine to arbitrary address/data width and block size, and adds a memory request handshake and optional critical-word-first ordering.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, memory/data-array word width in bits.
- WORDS_PER_BLOCK, 8, words per cache block; power of 2, >=2.
- BYTES_PER_WORD, 2, byte stride between consecutive words; power of 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_detected  in  1  tag logic reports a miss; sampled only in IDLE.
- miss_address  in  ADDR_W  address that missed.
- fsm_busy  out  1  high while a fill is in progress; used as the pipeline stall.
- memory_read  out  1  memory request valid.
- memory_ready  in  1  memory accepts the request this cycle.
- memory_address  out  ADDR_W  word address of the current request.
- memory_data  in  DATA_W  returned word; written straight into the data array.
- memory_data_valid  in  1  returned word valid this cycle.
- write_data_array  out  1  data-array write enable.
- fill_word_index  out  log2(WORDS_PER_BLOCK)  word slot written this cycle.
- write_tag_array  out  1  tag-array write enable, single-cycle pulse.

Behaviour:
- Derived widths:
  - OFF_W = log2(WORDS_PER_BLOCK*BYTES_PER_WORD).
  - IDX_W = log2(WORDS_PER_BLOCK).
- Reset (async, any state, including mid-fill):
  - state=IDLE; base, issue_cnt and recv_cnt cleared.
  - All outputs 0.
  - Any data returning after reset deasserts is ignored.
- IDLE:
  - fsm_busy=0, memory_read=0, memory_address=0.
  - When miss_detected=1, latch base = miss_address with the low OFF_W bits cleared, clear both counters, go to FILL.
  - fsm_busy rises in the cycle after the miss.
- FILL:
  - memory_read=1.
  - memory_address = base + (issue_idx * BYTES_PER_WORD), where issue_idx is the word being requested.
  - A request is accepted when memory_read && memory_ready; issue_cnt increments only on acceptance.
  - After accepting the request for the last word (issue_cnt == WORDS_PER_BLOCK-1), go to DRAIN.
  - memory_address holds steady while memory_ready=0.
- DRAIN:
  - memory_read=0, memory_address=0.
  - Wait for the remaining data to return.
- Receive path (FILL or DRAIN only):
  - write_data_array = memory_data_valid && fsm_busy, combinational, same cycle as the valid.
  - fill_word_index = index of the word for recv_cnt.
  - recv_cnt increments on each valid word.
  - Memory returns data in request order; no reordering is supported.
- Completion:
  - On the valid that makes recv_cnt reach WORDS_PER_BLOCK, write_tag_array=1 in the same cycle as the final data write.
  - Next state is IDLE; fsm_busy falls the cycle after the final write.
  - Completion may occur from FILL if memory has zero latency; completion takes priority over the FILL->DRAIN transition.
- Ignored inputs:
  - memory_data_valid in IDLE.
  - miss_detected while busy; the pipeline is stalled by fsm_busy.
- Back-to-back misses: a new miss may be accepted in the first IDLE cycle after completion.
- Address wrap: base + offset never carries out of the block, so no wrap beyond base is possible.
- Minimum fill latency is WORDS_PER_BLOCK + memory latency + 1 cycles.

Optional Feature:
- Macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Requested word order starts at the missed word's offset (miss_address[OFF_W-1:log2(BYTES_PER_WORD)]) and wraps modulo WORDS_PER_BLOCK.
  - fill_word_index follows the same rotated order.
  - Adds output crit_word_valid (1 bit): pulses with the first write_data_array of a fill, so the pipeline can forward that word early.
- Undefined:
  - Order is always 0..WORDS_PER_BLOCK-1.
  - crit_word_valid port does not exist.

Decomposition:
- Package cache_fill_pkg:
  - state_t enum {IDLE, FILL, DRAIN} (2-bit).
  - Localparam helpers for OFF_W/IDX_W computation.
- Sub-module fill_word_counter, instantiated twice (issue and receive):
  - Inputs: start, inc, start_idx.
  - Outputs: idx (rotated), count, last.

Test Plan:
- Default params, miss at 0x1236, memory_ready=1, 4-cycle data latency -> addresses 0x1230,0x1232..0x123E on 8 consecutive cycles; 8 data writes with index 0..7; write_tag_array coincides with the 8th write; fsm_busy high for exactly 8+4+1 cycles.
- memory_ready low for 3 cycles after the 2nd request -> memory_address holds 0x1232 during the stall; no duplicate or skipped address; all 8 words written.
- rst asserted mid-DRAIN after 5 words received -> all outputs 0 immediately; a subsequent memory_data_valid in IDLE causes no write; a new miss then completes normally.
- Second miss 0x4000 presented in the cycle fsm_busy falls -> accepted; first request at 0x4000 appears in the next cycle.
- WORDS_PER_BLOCK=4, DATA_W=32, BYTES_PER_WORD=4, miss 0x0018 -> addresses 0x0010,0x0014,0x0018,0x001C; write_tag_array after 4 writes.
- With CACHE_FILL_CRITICAL_WORD_FIRST_EN, miss 0x1236 -> order 0x1236,0x1238..0x123E,0x1230..0x1234; fill_word_index 3,4..7,0,1,2; crit_word_valid pulses once with the first write.
